// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and default widths for the run controller
package pipe_ctrl_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_CW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_halt_det.sv
// rtl/pipe_halt_det.sv - detects the core spinning on one PC across valid fetch samples
module pipe_halt_det
    import pipe_ctrl_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int HALT_REPEAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] pc_i,
    input  logic          pc_valid,
    output logic          hit
);

    localparam int HW = $clog2(HALT_REPEAT + 1);

    if (HALT_REPEAT < 2) begin : g_bad_repeat
        $error("pipe_halt_det: HALT_REPEAT must be at least 2");
    end

    logic [AW-1:0] last_pc;
    logic [HW-1:0] rep_cnt;
    logic          same;

    // rep_cnt==0 marks "no sample yet", so the first valid sample always reloads
    assign same = (rep_cnt != '0) && (pc_i == last_pc);
    assign hit  = !clr && pc_valid && same && (rep_cnt == HW'(HALT_REPEAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc <= '0;
            rep_cnt <= '0;
        end else if (clr) begin
            last_pc <= '0;
            rep_cnt <= '0;
        end else if (pc_valid) begin
            if (same) begin
                if (rep_cnt != HW'(HALT_REPEAT)) begin
                    rep_cnt <= rep_cnt + HW'(1);
                end
            end else begin
                last_pc <= pc_i;
                rep_cnt <= HW'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - core reset sequencer, cycle-budget watchdog and halt-based run finish
module pipe_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int CW          = DEF_CW,
    parameter int RST_CYC     = 2,
    parameter int MAX_CYC     = 300,
    parameter int HALT_REPEAT = 4,
    parameter int AUTO_START  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] pc_i,
    input  logic          pc_valid,
    output logic          core_rst_n,
    output logic          running,
    output logic          done,
    output logic          halted,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int RW = $clog2(RST_CYC + 1);
    localparam state_t RST_STATE = (AUTO_START != 0) ? ST_RESET : ST_IDLE;

    if (RST_CYC < 1) begin : g_bad_rst_cyc
        $error("pipe_run_ctrl: RST_CYC must be at least 1");
    end
    if (MAX_CYC < 1 || (longint'(MAX_CYC) >> CW) != 0) begin : g_bad_max_cyc
        $error("pipe_run_ctrl: MAX_CYC must lie in 1..2^CW-1");
    end

    state_t        state, state_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [CW-1:0] cycle_n;
    logic          halted_n, timeout_n;
    logic          hit;
    logic          det_clr;

    // The detector only observes RUN; any other state wipes its history
    assign det_clr = (state != ST_RUN);

    pipe_halt_det #(
        .AW          (AW),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk      (clk),
        .rst      (rst),
        .clr      (det_clr),
        .pc_i     (pc_i),
        .pc_valid (pc_valid),
        .hit      (hit)
    );

    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        cycle_n   = cycle_cnt;
        halted_n  = halted;
        timeout_n = timeout;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n   = ST_RESET;
                    rst_cnt_n = '0;
                    cycle_n   = '0;
                    halted_n  = 1'b0;
                    timeout_n = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt == RW'(RST_CYC - 1)) begin
                    state_n = ST_RUN;
                    cycle_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + RW'(1);
                end
            end
            ST_RUN: begin
                // Halt wins over budget expiry landing on the same cycle
                if (hit) begin
                    state_n  = ST_DONE;
                    halted_n = 1'b1;
                end else if (cycle_cnt == CW'(MAX_CYC - 1)) begin
                    state_n   = ST_DONE;
                    timeout_n = 1'b1;
                end else begin
                    cycle_n = cycle_cnt + CW'(1);
                end
            end
            default: begin
                state_n = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_STATE;
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            rst_cnt    <= rst_cnt_n;
            cycle_cnt  <= cycle_n;
            halted     <= halted_n;
            timeout    <= timeout_n;
            core_rst_n <= (state_n == ST_RUN);
            running    <= (state_n == ST_RUN);
            done       <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb/tb_pipe_run_ctrl.sv - directed scoreboard bench for pipe_run_ctrl (default and short-budget instances)
module tb_pipe_run_ctrl;

    localparam logic [31:0] J = 32'hDEAD_BEE0;

    typedef struct {
        int          id;
        logic        hlt;
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st     [2];
    logic [31:0] pc_in  [2];
    logic        pcv    [2];
    logic        crn    [2];
    logic        run    [2];
    logic        dn     [2];
    logic        hlt    [2];
    logic        tmo    [2];
    logic [31:0] cc     [2];

    exp_t        sb     [$];
    logic [31:0] seq_pc [$];
    bit          seq_v  [$];
    int          checks = 0;
    int          errors = 0;
    int          n_run;
    int          cyc;

    always #5 clk = ~clk;

    pipe_run_ctrl dut_a (
        .clk(clk), .rst(rst), .start(st[0]), .pc_i(pc_in[0]), .pc_valid(pcv[0]),
        .core_rst_n(crn[0]), .running(run[0]), .done(dn[0]), .halted(hlt[0]),
        .timeout(tmo[0]), .cycle_cnt(cc[0])
    );

    pipe_run_ctrl #(.MAX_CYC(10), .AUTO_START(0)) dut_b (
        .clk(clk), .rst(rst), .start(st[1]), .pc_i(pc_in[1]), .pc_valid(pcv[1]),
        .core_rst_n(crn[1]), .running(run[1]), .done(dn[1]), .halted(hlt[1]),
        .timeout(tmo[1]), .cycle_cnt(cc[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_running(input int sel, input int exp_len);
        int n = 0;
        while (!run[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_len", n, exp_len);
        chk("run_core_rst_n", crn[sel], 1);
        chk("run_cnt0", cc[sel], 0);
    endtask

    task automatic start_run(input int sel);
        st[sel] = 1'b1;
        @(negedge clk);
        st[sel] = 1'b0;
        chk("restart_done", dn[sel], 0);
        chk("restart_halted", hlt[sel], 0);
        chk("restart_timeout", tmo[sel], 0);
        chk("restart_cnt", cc[sel], 0);
        chk("restart_core_rst_n", crn[sel], 0);
        wait_running(sel, 2);
    endtask

    task automatic run_seq(input int sel);
        for (int i = 0; i < seq_pc.size(); i++) begin
            pc_in[sel] = seq_pc[i];
            pcv[sel]   = seq_v[i];
            @(negedge clk);
            chk("done_step", dn[sel], (i == seq_pc.size() - 1));
        end
        pcv[sel] = 1'b0;
    endtask

    task automatic check_sb(input int sel);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_pop observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_id", sel, e.id);
            chk("end_done", dn[sel], 1);
            chk("end_halted", hlt[sel], e.hlt);
            chk("end_timeout", tmo[sel], e.tmo);
            chk("end_cnt", cc[sel], e.cnt);
            chk("end_running", run[sel], 0);
            chk("end_core_rst_n", crn[sel], 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        st    = '{1'b0, 1'b0};
        pc_in = '{32'h0, 32'h0};
        pcv   = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_core_rst_n", crn[s], 0);
            chk("rst_running", run[s], 0);
            chk("rst_done", dn[s], 0);
            chk("rst_halted", hlt[s], 0);
            chk("rst_timeout", tmo[s], 0);
            chk("rst_cnt", cc[s], 0);
        end
        rst = 1'b0;
        wait_running(0, 2);
        chk("b_idle_core_rst_n", crn[1], 0);
        chk("b_idle_running", run[1], 0);

        // A: incrementing PC runs out the 300-cycle budget; start mid-run is ignored
        sb.push_back('{0, 1'b0, 1'b1, 32'd299});
        n_run = 1;
        cyc   = 0;
        while (!dn[0] && cyc < 400) begin
            pc_in[0] += 4;
            pcv[0]    = 1'b1;
            st[0]     = (cyc == 50);
            @(negedge clk);
            if (run[0]) n_run++;
            if (cyc == 52) begin
                chk("start_ignored", run[0], 1);
                chk("cnt_mid", cc[0], 53);
            end
            cyc++;
        end
        st[0]  = 1'b0;
        pcv[0] = 1'b0;
        chk("run_cycles", n_run, 300);
        check_sb(0);
        chk("b_still_idle_core_rst_n", crn[1], 0);
        chk("b_still_idle_running", run[1], 0);

        // A: straight spin on 0x8
        start_run(0);
        seq_pc = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
        seq_v  = '{1, 1, 1, 1, 1, 1};
        sb.push_back('{0, 1'b1, 1'b0, 32'd5});
        run_seq(0);
        check_sb(0);

        // A: spin with stall bubbles; 0xC restarts the count
        start_run(0);
        seq_pc = '{32'h8, J, J, J, 32'h8, J, J, J, 32'hC, 32'h8, J, J, J,
                   32'h8, J, J, J, 32'h8, J, J, J, 32'h8};
        seq_v  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0,
                   1, 0, 0, 0, 1, 0, 0, 0, 1};
        sb.push_back('{0, 1'b1, 1'b0, 32'd21});
        run_seq(0);
        check_sb(0);

        // B (budget 10): halt on the last budget cycle wins
        start_run(1);
        seq_pc = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h30, 32'h30, 32'h30};
        seq_v  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        sb.push_back('{1, 1'b1, 1'b0, 32'd9});
        run_seq(1);
        check_sb(1);

        // B: distinct PCs time out
        start_run(1);
        seq_pc = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
        sb.push_back('{1, 1'b0, 1'b1, 32'd9});
        run_seq(1);
        check_sb(1);

        // B: only three repeats by expiry is still a timeout
        start_run(1);
        seq_pc = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h40, 32'h40, 32'h40};
        sb.push_back('{1, 1'b0, 1'b1, 32'd9});
        run_seq(1);
        check_sb(1);

        // A: asynchronous reset between clock edges
        start_run(0);
        pcv[0] = 1'b1;
        repeat (3) begin
            pc_in[0] += 4;
            @(negedge clk);
        end
        chk("pre_rst_cnt", cc[0], 3);
        #2 rst = 1'b1;
        #1;
        chk("async_core_rst_n", crn[0], 0);
        chk("async_running", run[0], 0);
        chk("async_done", dn[0], 0);
        chk("async_cnt", cc[0], 0);
        chk("async_b_done", dn[1], 0);
        chk("async_b_timeout", tmo[1], 0);
        chk("async_b_cnt", cc[1], 0);
        pcv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_running(0, 2);
        chk("b_post_rst_core_rst_n", crn[1], 0);
        chk("b_post_rst_running", run[1], 0);

        // A: first sample after reset reloads even though it equals the cleared last_pc
        seq_pc = '{32'h0, 32'h0, 32'h0, 32'h0};
        seq_v  = '{1, 1, 1, 1};
        sb.push_back('{0, 1'b1, 1'b0, 32'd3});
        run_seq(0);
        check_sb(0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
